// File: rtl/systolic_data_setup.sv
// Input skew stage for the systolic array: extends each lane byte and
// delays lane i by i cycles to form the diagonal wavefront.
module systolic_data_setup #(
    parameter int MATRIX_WIDTH        = 14,
    parameter int BYTE_WIDTH          = 8,
    parameter int EXTENDED_BYTE_WIDTH = 9
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       enable,
    input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]          data_in,
    input  logic                                       data_valid_in,
    input  logic                                       signed_data,
    output logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0] data_out,
    output logic [MATRIX_WIDTH-1:0]                    valid_out,
    output logic                                       busy,
    output logic                                       drain_done
);

    localparam int BW = BYTE_WIDTH;
    localparam int EW = EXTENDED_BYTE_WIDTH;

    logic [MATRIX_WIDTH-1:0] lane_busy;
    logic                    busy_q;

    for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_lane
        logic [BW-1:0] lane_byte;
        logic [EW-1:0] lane_ext;
        // d_q[0] is the input stage; d_q[1..i] are the skew delays
        logic [EW-1:0] d_q [i+1];
        logic [i:0]    v_q;

        assign lane_byte = data_in[i*BW +: BW];
        // Bubbles are stored as zero so downstream MACs accumulate nothing
        assign lane_ext  = data_valid_in
                         ? {{(EW-BW){signed_data & lane_byte[BW-1]}}, lane_byte}
                         : '0;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    d_q[j] <= '0;
                end
                v_q <= '0;
            end else if (enable) begin
                d_q[0] <= lane_ext;
                v_q[0] <= data_valid_in;
                for (int j = 1; j <= i; j++) begin
                    d_q[j] <= d_q[j-1];
                    v_q[j] <= v_q[j-1];
                end
            end
        end

        assign data_out[i*EW +: EW] = d_q[i];
        assign valid_out[i]         = v_q[i];
        assign lane_busy[i]         = |v_q;
    end

    assign busy = |lane_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            drain_done <= 1'b0;
        end else if (enable) begin
            busy_q     <= busy;
            drain_done <= busy_q & ~busy;
        end
    end

endmodule

// File: tb/tb_systolic_data_setup.sv
// Directed bench for systolic_data_setup with MATRIX_WIDTH=4.
// Hand-computed checks for the basic cases, a small lane model elsewhere.
module tb_systolic_data_setup;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] data_in;
    logic        data_valid_in;
    logic        signed_data;
    logic [35:0] data_out;
    logic [3:0]  valid_out;
    logic        busy;
    logic        drain_done;

    int n_vec = 0;
    int n_err = 0;

    // model: history of extended vectors per enabled edge since reset
    logic [8:0] hd [256][4];
    logic       hv [256];
    logic       hb [256];
    int         e  = -1;

    systolic_data_setup #(.MATRIX_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .data_in(data_in),
        .data_valid_in(data_valid_in),
        .signed_data(signed_data),
        .data_out(data_out),
        .valid_out(valid_out),
        .busy(busy),
        .drain_done(drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] pk(
        input logic [8:0] a, input logic [8:0] b,
        input logic [8:0] c, input logic [8:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic busy_at(input int k);
        if (k < 0) return 1'b0;
        return hb[k];
    endfunction

    task automatic step(input logic r, input logic en, input logic vld,
                        input logic sd, input logic [31:0] b,
                        input string tag);
        logic [35:0] ed;
        logic [3:0]  ev;
        logic        eb;
        logic        edd;
        logic [7:0]  by;
        rst = r;
        enable = en;
        data_valid_in = vld;
        signed_data = sd;
        data_in = b;
        @(posedge clk);
        #1;
        if (r) begin
            e = -1;
        end else if (en) begin
            e++;
            for (int i = 0; i < 4; i++) begin
                by = b[i*8 +: 8];
                hd[e][i] = vld ? {sd & by[7], by} : 9'h000;
            end
            hv[e] = vld;
            hb[e] = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (e - j >= 0 && hv[e-j]) hb[e] = 1'b1;
            end
        end
        ed = '0;
        ev = '0;
        for (int i = 0; i < 4; i++) begin
            if (e - i >= 0) begin
                ed[i*9 +: 9] = hd[e-i][i];
                ev[i] = hv[e-i];
            end
        end
        eb  = busy_at(e);
        edd = busy_at(e-2) & ~busy_at(e-1);
        n_vec++;
        assert (data_out === ed) else begin
            n_err++;
            $error("FAIL %s data_out got %h expected %h", tag, data_out, ed);
        end
        n_vec++;
        assert (valid_out === ev) else begin
            n_err++;
            $error("FAIL %s valid_out got %b expected %b", tag, valid_out, ev);
        end
        n_vec++;
        assert (busy === eb) else begin
            n_err++;
            $error("FAIL %s busy got %b expected %b", tag, busy, eb);
        end
        n_vec++;
        assert (drain_done === edd) else begin
            n_err++;
            $error("FAIL %s drain_done got %b expected %b", tag, drain_done, edd);
        end
    endtask

    task automatic hand(input logic [35:0] d, input logic [3:0] v,
                        input logic b, input logic dd, input string tag);
        n_vec++;
        assert (data_out === d && valid_out === v) else begin
            n_err++;
            $error("FAIL %s hand data/valid got %h/%b expected %h/%b",
                   tag, data_out, valid_out, d, v);
        end
        n_vec++;
        assert (busy === b && drain_done === dd) else begin
            n_err++;
            $error("FAIL %s hand busy/drain got %b/%b expected %b/%b",
                   tag, busy, drain_done, b, dd);
        end
    endtask

    initial begin
        logic [31:0]  b;
        logic [13:0]  pat;
        int           vi;
        rst = 1'b1;
        enable = 1'b0;
        data_in = '0;
        data_valid_in = 1'b0;
        signed_data = 1'b0;

        // reset wins over enable and a valid input
        step(1, 1, 1, 1, 32'hFFFFFFFF, "reset");
        hand(36'h0, 4'b0000, 0, 0, "reset");

        // single unsigned vector
        step(0, 1, 1, 0, 32'h04030201, "single0");
        hand(pk(9'h001, 0, 0, 0), 4'b0001, 1, 0, "single0");
        step(0, 1, 0, 0, 32'hDEADBEEF, "single1");
        hand(pk(0, 9'h002, 0, 0), 4'b0010, 1, 0, "single1");
        step(0, 1, 0, 0, 32'h0, "single2");
        hand(pk(0, 0, 9'h003, 0), 4'b0100, 1, 0, "single2");
        step(0, 1, 0, 0, 32'h0, "single3");
        hand(pk(0, 0, 0, 9'h004), 4'b1000, 1, 0, "single3");
        step(0, 1, 0, 0, 32'h0, "single4");
        hand(36'h0, 4'b0000, 0, 0, "single4");
        step(0, 1, 0, 0, 32'h0, "single5");
        hand(36'h0, 4'b0000, 0, 1, "single5");
        step(0, 1, 0, 0, 32'h0, "single6");
        hand(36'h0, 4'b0000, 0, 0, "single6");

        // signed then unsigned, same bytes, back to back
        step(0, 1, 1, 1, 32'h007FFF80, "sign0");
        hand(pk(9'h180, 0, 0, 0), 4'b0001, 1, 0, "sign0");
        step(0, 1, 1, 0, 32'h007FFF80, "sign1");
        hand(pk(9'h080, 9'h1FF, 0, 0), 4'b0011, 1, 0, "sign1");
        step(0, 1, 0, 1, 32'hFFFFFFFF, "sign2");
        hand(pk(0, 9'h0FF, 9'h07F, 0), 4'b0110, 1, 0, "sign2");
        step(0, 1, 0, 0, 32'h0, "sign3");
        hand(pk(0, 0, 9'h07F, 9'h000), 4'b1100, 1, 0, "sign3");
        step(0, 1, 0, 0, 32'h0, "sign4");
        hand(pk(0, 0, 0, 9'h000), 4'b1000, 1, 0, "sign4");
        step(0, 1, 0, 0, 32'h0, "sign5");
        step(0, 1, 0, 0, 32'h0, "sign6");
        hand(36'h0, 4'b0000, 0, 1, "sign6");
        step(0, 1, 0, 0, 32'h0, "sign7");

        // streaming 8 vectors, mixed signedness and high bits
        for (int k = 0; k < 8; k++) begin
            for (int l = 0; l < 4; l++) b[l*8 +: 8] = 8'(k*32 + l*5 + 1);
            step(0, 1, 1, k[0], b, "stream");
        end
        for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 32'h0, "stream_drain");

        // stall after 2nd of 4 vectors; junk presented while stalled
        pat = 14'b10111111100011;
        vi = 0;
        for (int t = 0; t < 14; t++) begin
            if (!pat[t]) begin
                step(0, 0, 1, 1, 32'hA5A5A5A5, "stall_hold");
            end else if (vi < 4) begin
                for (int l = 0; l < 4; l++) b[l*8 +: 8] = 8'(8'h90 + vi*4 + l);
                step(0, 1, 1, 0, b, "stall_vec");
                vi++;
            end else begin
                step(0, 1, 0, 0, 32'h0, "stall_drain");
            end
        end

        // bubble between two valid vectors
        step(0, 1, 1, 0, 32'h44332211, "bubble0");
        step(0, 1, 0, 0, 32'h12345678, "bubble1");
        step(0, 1, 1, 1, 32'hC8B7A695, "bubble2");
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 32'h0, "bubble_drain");

        // new vector enters as the old one leaves lane 3
        step(0, 1, 1, 0, 32'h0D0C0B0A, "overlap0");
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 32'h0, "overlap_gap");
        step(0, 1, 1, 0, 32'h1D1C1B1A, "overlap1");
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 32'h0, "overlap_drain");

        // reset with three vectors in flight
        step(0, 1, 1, 0, 32'h03020100, "mid0");
        step(0, 1, 1, 1, 32'h83828180, "mid1");
        step(0, 1, 1, 0, 32'h13121110, "mid2");
        step(1, 1, 1, 0, 32'h77777777, "mid_rst");
        hand(36'h0, 4'b0000, 0, 0, "mid_rst");
        step(0, 1, 0, 0, 32'h0, "mid_idle0");
        step(0, 1, 0, 0, 32'h0, "mid_idle1");
        hand(36'h0, 4'b0000, 0, 0, "mid_idle1");
        step(0, 1, 1, 1, 32'hF1E2D3C4, "post_rst");
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 32'h0, "post_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_data_setup.md
# systolic_data_setup

Input skew stage for the systolic array. Accepts one row-vector of MATRIX_WIDTH bytes per cycle from the unified buffer read path, extends each byte to an extended byte (signed or unsigned), and delays lane i by i cycles. The diagonal wavefront it produces drives the `data_in` ports of the MAC units at the left edge of the array, so that lane i meets row i of the array one cycle after lane i-1.

## Interface
- MATRIX_WIDTH, 14, number of lanes; equals the array dimension; legal range 2..64.
- BYTE_WIDTH, 8 (tpu_pkg), input lane width.
- EXTENDED_BYTE_WIDTH, 9 (tpu_pkg), output lane width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global advance; 0 freezes every register and ignores all inputs.
- data_in  in  MATRIX_WIDTH*BYTE_WIDTH  input vector; lane i is bits [i*8 +: 8].
- data_valid_in  in  1  data_in holds a real vector this cycle.
- signed_data  in  1  1 sign-extends lane bytes; 0 zero-extends. Sampled together with data_in.
- data_out  out  MATRIX_WIDTH*EXTENDED_BYTE_WIDTH  skewed extended lanes; lane i is bits [i*9 +: 9].
- valid_out  out  MATRIX_WIDTH  per-lane valid; bit i qualifies lane i of data_out.
- busy  out  1  at least one valid element is in flight (OR of all internal valid bits).
- drain_done  out  1  one-cycle pulse when busy falls from 1 to 0.

## Operation
- Input stage: when enable=1, register all lanes. Each lane is extended with bit 8 = signed_data ? byte[7] : 0, and its valid bit = data_valid_in. If data_valid_in=0, store lane value 0 and valid 0. The lanes are bubbles.
- Lane i, for i ≥ 1, then passes through i further shift registers (data + valid). Lane 0 has none. Total storage is MATRIX_WIDTH*(MATRIX_WIDTH+1)/2 extended bytes plus the matching valid bits.
- data_out lane i and valid_out[i] are driven straight from the last register of lane i. There is no combinational path from any input to any output.
- Bubbles propagate as data 0 / valid 0. Downstream MAC accumulation therefore adds 0 for lanes without data.
- signed_data is captured per vector. Consecutive vectors with different signedness stay correctly extended while in flight.
- busy: OR over every valid bit in the input stage and all delay stages.
- drain_done: registered. It is 1 for exactly one cycle after a cycle in which busy went 1→0. It only asserts while enable=1.
- Reset: clears all data registers to 0 and all valid bits to 0. Reset has priority over enable.
  - A reset in the middle of a stream discards every in-flight element.
  - No drain_done pulse is generated by reset.

## Timing
- Reset values: data_out=0, valid_out=0, busy=0, drain_done=0.
- Latency: a vector sampled at enabled edge T appears on lane i at enabled edge T+1+i, and is visible after that edge.
  - Lane 0 latency is 1 enabled cycle.
  - Lane MATRIX_WIDTH-1 latency is MATRIX_WIDTH enabled cycles.
- Throughput: one vector per enabled cycle with no back-pressure. The block has no ready output; the consumer must accept every cycle enable=1.
- Stall: when enable=0, outputs hold their values and nothing is sampled.
  - Latency counts only enabled cycles.
  - drain_done, if it is high, is held through the stall. It is cleared on the next enabled edge.
- Full drain: after the last valid vector is sampled at edge T, busy falls after enabled edge T+MATRIX_WIDTH. drain_done is high after edge T+MATRIX_WIDTH+1.
- Simultaneous events:
  - A new valid vector arriving on the same edge that the last lane of an older vector exits keeps busy=1, and no drain_done is generated.
  - If rst and enable are both 1, reset wins.

## Test plan
- MATRIX_WIDTH=4. Reset, then one valid vector with lanes {0x01,0x02,0x03,0x04} and signed_data=0 -> valid_out is 0001, 0010, 0100, 1000 on consecutive cycles. Lane data is 0x001, 0x002, 0x003, 0x004. busy falls after 4 cycles, then drain_done pulses once.
- Sign extension: lanes {0x80,0xFF,0x7F,0x00}, first with signed_data=1 -> outputs 0x180, 0x1FF, 0x07F, 0x000. The same bytes with signed_data=0 on the next cycle -> 0x080, 0x0FF, 0x07F, 0x000. Each lane carries both vectors back to back with the correct extensions.
- Streaming: 8 consecutive valid vectors -> every lane shows all 8 vectors in order. busy stays 1 throughout, and drain_done pulses exactly once, 5 cycles after the last input.
- Stall: insert enable=0 for 3 cycles after the 2nd of 4 vectors -> outputs frozen during the stall. Sequence and per-lane ordering are unchanged, and total latency grows by exactly 3 cycles.
- Bubbles: pattern valid, invalid, valid -> each lane shows data, then 0 with valid 0, then data. busy never drops between the two valid vectors.
- Reset mid-stream: assert rst while 3 vectors are in flight -> next cycle all outputs and busy are 0 and no drain_done pulse occurs. A vector sent after reset follows normal latency.
